// File: rtl/prefetch_queue.sv
// Instruction prefetch queue feeding the decoder from longword reads on the bus unit request port.
// Optional bus-error tagging is enabled with `define PREFETCH_BERR_EN.
//
// state | meaning
// IDLE  | not running, waiting for the first flush after reset
// RUN   | may issue a longword request
// WAIT  | one request outstanding, its data will be queued
// DRAIN | one request outstanding, its data will be dropped
module prefetch_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        i_Flush,
   input  logic [31:0] i_FlushAddr,
   output logic        o_Valid,
   output logic [15:0] o_Word,
   input  logic        i_Ack,
   output logic        o_BReq,
   output logic [31:0] o_AddrReq,
   output logic [1:0]  o_SizeReq,
   input  logic        i_BReqComplete,
`ifdef PREFETCH_BERR_EN
   input  logic        i_BErr,
   output logic        o_Fault,
`endif
   input  logic [31:0] i_Data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam logic [PTR_W:0]   ISSUE_MAX = (PTR_W+1)'(DEPTH - 2);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_TWO   = (PTR_W+1)'(2);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_TWO   = PTR_W'(2);

   logic [1:0]       state;
   logic [PTR_W:0]   count;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [29:0]      fetch_addr;
   logic             skip_high;
   logic [31:0]      addr_hold;
   logic [15:0]      mem [DEPTH];
   logic             halt;

   logic             issue;
   logic             accept;
   logic             ack_take;
   logic [PTR_W:0]   cnt_add;
   logic [PTR_W:0]   cnt_sub;
   logic             unused_flush_bit0;

   assign unused_flush_bit0 = i_FlushAddr[0];

   always_comb begin
      o_Valid  = (count != '0);
      ack_take = i_Ack && o_Valid && !i_Flush;
      // A flush in the issue cycle wins; the request simply never goes out.
      issue    = (state == ST_RUN) && (count <= ISSUE_MAX) && !halt && !i_Flush;
      accept   = (state == ST_WAIT) && i_BReqComplete && !i_Flush;
      cnt_add  = '0;
      if (accept) cnt_add = skip_high ? CNT_ONE : CNT_TWO;
      cnt_sub  = ack_take ? CNT_ONE : '0;
   end

   assign o_BReq    = issue;
   assign o_AddrReq = issue ? {fetch_addr, 2'b00} : addr_hold;
   assign o_SizeReq = 2'b00;
   assign o_Word    = mem[head];

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state      <= ST_IDLE;
         count      <= '0;
         head       <= '0;
         tail       <= '0;
         fetch_addr <= '0;
         skip_high  <= 1'b0;
         addr_hold  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (issue) addr_hold <= {fetch_addr, 2'b00};
         if (i_Flush) begin
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            fetch_addr <= i_FlushAddr[31:2];
            skip_high  <= i_FlushAddr[1];
            if ((state == ST_WAIT || state == ST_DRAIN) && !i_BReqComplete)
               state <= ST_DRAIN;
            else
               state <= ST_RUN;
         end else begin
            case (state)
               ST_RUN:   if (issue) state <= ST_WAIT;
               ST_WAIT:  if (i_BReqComplete) state <= ST_RUN;
               ST_DRAIN: if (i_BReqComplete) state <= ST_RUN;
               default:  ;
            endcase
            if (accept) begin
               fetch_addr <= fetch_addr + 30'd1;
               skip_high  <= 1'b0;
               if (skip_high) begin
                  mem[tail] <= i_Data[15:0];
                  tail      <= tail + PTR_ONE;
               end else begin
                  mem[tail]           <= i_Data[31:16];
                  mem[tail + PTR_ONE] <= i_Data[15:0];
                  tail                <= tail + PTR_TWO;
               end
            end
            if (ack_take) head <= head + PTR_ONE;
            count <= count + cnt_add - cnt_sub;
         end
      end
   end

`ifdef PREFETCH_BERR_EN
   logic fault_mem [DEPTH];

   assign o_Fault = o_Valid && fault_mem[head];

   // A faulted completion stops fetching until the next flush.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         halt <= 1'b0;
         for (int i = 0; i < DEPTH; i++) fault_mem[i] <= 1'b0;
      end else if (i_Flush) begin
         halt <= 1'b0;
      end else if (accept) begin
         halt <= i_BErr;
         fault_mem[tail] <= i_BErr;
         if (!skip_high) fault_mem[tail + PTR_ONE] <= i_BErr;
      end
   end
`else
   assign halt = 1'b0;
`endif

endmodule
